// File: rtl/ysyx_24110015_wbu.sv
// ysyx_24110015_wbu: write-back unit with 2-entry result FIFO and RAW pending-write scoreboard
// YSYX_24110015_WBU_RETIRE_EN adds retire_valid/retire_pc commit tracing.
module ysyx_24110015_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0] in_alu,
  input  logic [DATA_WIDTH-1:0] in_load_raw,
  input  logic [2:0]            in_load_fn,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_csr,
  input  logic                  hold,
  input  logic                  claim_valid,
  input  logic [ADDR_WIDTH-1:0] claim_rd,
  input  logic [ADDR_WIDTH-1:0] hz_raddr1,
  input  logic [ADDR_WIDTH-1:0] hz_raddr2,
  output logic                  hz_busy1,
  output logic                  hz_busy2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  retire_valid,
  output logic [DATA_WIDTH-1:0] retire_pc
);
  localparam int NREG = 1 << ADDR_WIDTH;
  logic [7:0]            lb;
  logic [15:0]           lh;
  logic [DATA_WIDTH-1:0] ld, res;
  logic [1:0]            count;
  logic                  rptr, wptr, push, pop, nonempty;
  logic                  mem_wen [2];
  logic [ADDR_WIDTH-1:0] mem_rd [2];
  logic [DATA_WIDTH-1:0] mem_data [2];
  logic [NREG-1:0]       busy, busy_next;
  always_comb begin
    lb  = in_load_raw[8*in_addr_lo +: 8];
    lh  = in_addr_lo[1] ? in_load_raw[31:16] : in_load_raw[15:0];
    ld  = in_load_fn == 3'd0 ? {{(DATA_WIDTH-8){lb[7]}}, lb} :
          in_load_fn == 3'd1 ? {{(DATA_WIDTH-16){lh[15]}}, lh} :
          in_load_fn == 3'd2 ? in_load_raw :
          in_load_fn == 3'd4 ? {{(DATA_WIDTH-8){1'b0}}, lb} :
          in_load_fn == 3'd5 ? {{(DATA_WIDTH-16){1'b0}}, lh} : '0;
    res = in_sel == 2'd0 ? in_alu :
          in_sel == 2'd1 ? ld :
          in_sel == 2'd2 ? in_pc + DATA_WIDTH'(4) : in_csr;
  end
  assign nonempty = count != 2'd0;
  assign in_ready = count != 2'd2;
  assign push     = in_valid && in_ready;
  assign pop      = nonempty && !hold;
  assign rf_wen   = pop && mem_wen[rptr] && mem_rd[rptr] != '0;
  assign rf_waddr = nonempty ? mem_rd[rptr] : '0;
  assign rf_wdata = nonempty ? mem_data[rptr] : '0;
  assign hz_busy1 = busy[hz_raddr1];
  assign hz_busy2 = busy[hz_raddr2];
  // clear before set so a same-cycle claim wins; bit 0 never becomes pending
  assign busy_next = ((busy & ~(NREG'(rf_wen) << rf_waddr)) | (NREG'(claim_valid) << claim_rd))
                     & ~NREG'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      busy  <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_wen[i]  <= 1'b0;
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_wen[wptr]  <= in_wen;
        mem_rd[wptr]   <= in_rd;
        mem_data[wptr] <= res;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      busy  <= busy_next;
    end
  end
`ifdef YSYX_24110015_WBU_RETIRE_EN
  logic [DATA_WIDTH-1:0] mem_pc [2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_pc[i] <= '0;
    end else if (push) begin
      mem_pc[wptr] <= in_pc;
    end
  end
  assign retire_valid = pop;
  assign retire_pc    = nonempty ? mem_pc[rptr] : '0;
`else
  assign retire_valid = 1'b0;
  assign retire_pc    = '0;
`endif
endmodule
